control_de_operandos: RTL and testbench

- Sequencing controller behind the keypad reading system: consumes each latched key (digit / clear / save), acknowledges it with a one-cycle `key_ack` pulse, and assembles two decimal operands of up to NUM_DIGITS digits each.
- On the second save it computes and holds the sum.
- Provides the value to display and the entry state to the display/top level.

---
 rtl/control_de_operandos.sv | 176 +++++++++++++++++
 tb/tb_control_de_operandos.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/control_de_operandos.sv
// control_de_operandos
//   Sequencing controller behind the keypad reader. Each latched key (digit,
//   clear or save) is consumed once and acknowledged with a one-cycle key_ack
//   pulse. Two decimal operands of up to NUM_DIGITS digits are assembled, and
//   their sum is computed and held on the second save.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   key_valid     reader holds a latched key until acknowledged
//   key_num       digit of the latched key (0-9 meaningful)
//   key_clear     latched key is clear (qualified by key_valid)
//   key_save      latched key is save/enter (qualified by key_valid)
//   key_ack       one-cycle pulse: key consumed
//   operand_a     committed operand A
//   operand_b     committed operand B
//   result        registered operand_a + operand_b
//   result_valid  high while the sum is being shown
//   display_value entry being typed, or the result once done
//   digit_count   digits in the current entry
//   state_out     0 = entering A, 1 = entering B, 2 = done
module control_de_operandos #(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_WIDTH  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [3:0]           key_num,
  input  logic                 key_clear,
  input  logic                 key_save,
  output logic                 key_ack,
  output logic [BIN_WIDTH-1:0] operand_a,
  output logic [BIN_WIDTH-1:0] operand_b,
  output logic [BIN_WIDTH:0]   result,
  output logic                 result_valid,
  output logic [BIN_WIDTH:0]   display_value,
  output logic [1:0]           digit_count,
  output logic [1:0]           state_out
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_DONE = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  localparam logic [1:0] MAX_CNT = 2'(NUM_DIGITS);
  localparam int         WIDE_W  = BIN_WIDTH + 4;

  // Append one decimal digit to the accumulated entry (unsigned, truncated).
  function automatic logic [BIN_WIDTH-1:0] shift_in_digit(
    input logic [BIN_WIDTH-1:0] acc,
    input logic [3:0]           d
  );
    logic [WIDE_W-1:0] wide;
    wide = ({4'd0, acc} * WIDE_W'(10)) + WIDE_W'(d);
    return wide[BIN_WIDTH-1:0];
  endfunction

  // Zero-extended sum so the carry out of the top bit is kept.
  function automatic logic [BIN_WIDTH:0] add_operands(
    input logic [BIN_WIDTH-1:0] x,
    input logic [BIN_WIDTH-1:0] y
  );
    return {1'b0, x} + {1'b0, y};
  endfunction

  state_t               state, state_n;
  logic [BIN_WIDTH-1:0] entry, entry_n;
  logic [1:0]           count, count_n;
  logic [BIN_WIDTH-1:0] opa_n, opb_n;
  logic [BIN_WIDTH:0]   res_n;
  logic                 armed, armed_n;
  logic                 ack_n;
  logic                 accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_A;
      entry     <= '0;
      count     <= '0;
      operand_a <= '0;
      operand_b <= '0;
      result    <= '0;
      armed     <= 1'b1;
      key_ack   <= 1'b0;
    end else begin
      state     <= state_n;
      entry     <= entry_n;
      count     <= count_n;
      operand_a <= opa_n;
      operand_b <= opb_n;
      result    <= res_n;
      armed     <= armed_n;
      key_ack   <= ack_n;
    end
  end

  assign accept = key_valid & armed;

  always_comb begin
    state_n = state;
    entry_n = entry;
    count_n = count;
    opa_n   = operand_a;
    opb_n   = operand_b;
    res_n   = result;
    ack_n   = 1'b0;
    // Re-arm only once the reader has dropped key_valid, so a held key
    // is consumed exactly once.
    armed_n = armed | ~key_valid;

    if (state == S_BAD) begin
      // Unreachable encoding: recover to a clean S_A, keys wait.
      state_n = S_A;
      entry_n = '0;
      count_n = '0;
      opa_n   = '0;
      opb_n   = '0;
      res_n   = '0;
    end else if (accept) begin
      ack_n   = 1'b1;
      armed_n = 1'b0;
      if (key_clear) begin
        if (count != 2'd0) begin
          entry_n = '0;
          count_n = '0;
        end else begin
          opa_n   = '0;
          opb_n   = '0;
          res_n   = '0;
          entry_n = '0;
          state_n = S_A;
        end
      end else if (key_save) begin
        case (state)
          S_A: begin
            opa_n   = entry;
            entry_n = '0;
            count_n = '0;
            state_n = S_B;
          end
          S_B: begin
            opb_n   = entry;
            res_n   = add_operands(operand_a, entry);
            entry_n = '0;
            count_n = '0;
            state_n = S_DONE;
          end
          default: ;
        endcase
      end else if (key_num <= 4'd9) begin
        if (state == S_DONE) begin
          // A new digit after a result starts a fresh calculation.
          opa_n   = '0;
          opb_n   = '0;
          res_n   = '0;
          entry_n = BIN_WIDTH'(key_num);
          count_n = 2'd1;
          state_n = S_A;
        end else if (count < MAX_CNT) begin
          entry_n = shift_in_digit(entry, key_num);
          count_n = count + 2'd1;
        end
      end
    end
  end

  assign result_valid  = (state == S_DONE);
  assign display_value = (state == S_DONE) ? result : {1'b0, entry};
  assign digit_count   = count;
  assign state_out     = state;

endmodule

// File: tb/tb_control_de_operandos.sv
module tb_control_de_operandos;

  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_num = 4'd0;
  logic          key_clear = 1'b0;
  logic          key_save = 1'b0;
  logic          key_ack;
  logic [BW-1:0] operand_a, operand_b;
  logic [BW:0]   result, display_value;
  logic          result_valid;
  logic [1:0]    digit_count, state_out;

  control_de_operandos #(.NUM_DIGITS(3), .BIN_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_num(key_num),
    .key_clear(key_clear), .key_save(key_save), .key_ack(key_ack),
    .operand_a(operand_a), .operand_b(operand_b), .result(result),
    .result_valid(result_valid), .display_value(display_value),
    .digit_count(digit_count), .state_out(state_out)
  );

  always #10 clk = ~clk;

  typedef struct {
    int disp; int st; int cnt; int a; int b; int res; int rv;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int ack_cnt = 0;

  // Reference model of the operand entry behaviour.
  int m_state, m_entry, m_cnt, m_a, m_b, m_res;

  always @(negedge clk) if (key_ack === 1'b1) ack_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_entry = 0; m_cnt = 0; m_a = 0; m_b = 0; m_res = 0;
  endtask

  task automatic model_key(input int n, input bit c, input bit s);
    if (c) begin
      if (m_cnt > 0) begin
        m_entry = 0; m_cnt = 0;
      end else begin
        m_a = 0; m_b = 0; m_res = 0; m_entry = 0; m_state = 0;
      end
    end else if (s) begin
      if (m_state == 0) begin
        m_a = m_entry; m_entry = 0; m_cnt = 0; m_state = 1;
      end else if (m_state == 1) begin
        m_b = m_entry; m_res = m_a + m_entry; m_entry = 0; m_cnt = 0; m_state = 2;
      end
    end else if (n <= 9) begin
      if (m_state == 2) begin
        m_a = 0; m_b = 0; m_res = 0; m_entry = n; m_cnt = 1; m_state = 0;
      end else if (m_cnt < 3) begin
        m_entry = m_entry * 10 + n; m_cnt++;
      end
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.st = m_state; e.cnt = m_cnt; e.a = m_a; e.b = m_b; e.res = m_res;
    e.disp = (m_state == 2) ? m_res : m_entry;
    e.rv = (m_state == 2) ? 1 : 0;
    return e;
  endfunction

  task automatic compare_all(input exp_t e);
    check("display_value", int'(display_value), e.disp);
    check("state_out", int'(state_out), e.st);
    check("digit_count", int'(digit_count), e.cnt);
    check("operand_a", int'(operand_a), e.a);
    check("operand_b", int'(operand_b), e.b);
    check("result", int'(result), e.res);
    check("result_valid", int'(result_valid), e.rv);
  endtask

  task automatic press(input logic [3:0] n, input logic c, input logic s);
    bit got;
    model_key(int'(n), c, s);
    sb.push_back(snapshot());
    @(negedge clk);
    key_num = n; key_clear = c; key_save = s; key_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (key_ack === 1'b1) begin got = 1; break; end
    end
    check("ack_seen", int'(got), 1);
    compare_all(sb.pop_front());
    @(negedge clk);
    key_valid = 1'b0; key_clear = 1'b0; key_save = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", int'(key_ack), 0);
  endtask

  task automatic check_zero_outputs();
    model_reset();
    compare_all(snapshot());
    check("reset_key_ack", int'(key_ack), 0);
  endtask

  initial begin
    int a0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_zero_outputs();
    @(negedge clk) rst_n = 1'b1;

    // Reset in the middle of an entry, asserted away from the clock edge.
    press(4'd4, 0, 0);
    press(4'd2, 0, 0);
    #3 rst_n = 1'b0;
    #1 check_zero_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    press(4'd1, 0, 0);
    press(4'd0, 1, 0);

    // Full sequence: 123 + 456.
    a0 = ack_cnt;
    press(4'd1, 0, 0); press(4'd2, 0, 0); press(4'd3, 0, 0); press(4'd0, 0, 1);
    press(4'd4, 0, 0); press(4'd5, 0, 0); press(4'd6, 0, 0); press(4'd0, 0, 1);
    check("full_seq_acks", ack_cnt - a0, 8);
    check("full_seq_result", int'(result), 579);

    // Restart from done, clear/save priority, out-of-range digit.
    press(4'd2, 0, 0);
    press(4'd0, 1, 1);
    press(4'd7, 0, 0);
    a0 = ack_cnt;
    press(4'd12, 0, 0);
    check("ignored_key_acked", ack_cnt - a0, 1);

    // Saturation and empty save.
    press(4'd0, 1, 0);
    press(4'd0, 1, 0);
    press(4'd9, 0, 0); press(4'd9, 0, 0); press(4'd9, 0, 0); press(4'd7, 0, 0);
    press(4'd0, 0, 1);
    press(4'd0, 0, 1);
    check("sat_result", int'(result), 999);
    press(4'd0, 0, 1);

    // Clear semantics.
    press(4'd7, 0, 0); press(4'd8, 0, 0); press(4'd0, 1, 0);
    press(4'd0, 0, 1); press(4'd5, 0, 0); press(4'd0, 1, 0); press(4'd0, 1, 0);
    check("clear_state", int'(state_out), 0);

    // Held key_valid is consumed once; re-presented key is consumed again.
    model_key(3, 0, 0);
    sb.push_back(snapshot());
    @(negedge clk);
    key_num = 4'd3; key_valid = 1'b1;
    a0 = ack_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("hold_acks", ack_cnt - a0, 1);
    compare_all(sb.pop_front());
    @(negedge clk) key_valid = 1'b0;
    press(4'd3, 0, 0);
    check("hold_entry", int'(display_value), 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
